// File: rtl/scramble_core_wrapper.sv
// scramble_core_wrapper: BLE data whitening stage in the TX bit chain.
// The first HEADER_BIT_LEN bits of each packet (preamble + access address)
// pass through unchanged; every later bit (PDU + CRC) is XORed with the
// x^7+x^4+1 whitening sequence seeded from the latched channel index.
// Output is registered with exactly one clock of latency.
//
// Ports:
//   clk                                  system clock
//   rst                                  synchronous, active-high reset
//   channel_number[5:0]                  BLE channel index 0..39
//   channel_number_load                  latch channel_number (IDLE only)
//   info_bit / info_bit_valid            input bit and its single-cycle qualifier
//   info_bit_valid_last                  with valid: last bit of packet
//   info_bit_after_whitening             whitened / passed bit (holds when not valid)
//   info_bit_after_whitening_valid       output qualifier
//   info_bit_after_whitening_valid_last  with valid: last bit of packet
module scramble_core_wrapper #(
    parameter int unsigned HEADER_BIT_LEN  = 40,
    parameter int unsigned DEFAULT_CHANNEL = 37,
    parameter int unsigned BIT_COUNT_WIDTH = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] channel_number,
    input  logic       channel_number_load,
    input  logic       info_bit,
    input  logic       info_bit_valid,
    input  logic       info_bit_valid_last,
    output logic       info_bit_after_whitening,
    output logic       info_bit_after_whitening_valid,
    output logic       info_bit_after_whitening_valid_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        WHITEN = 2'd2
    } state_t;

    localparam logic [5:0]                 DEFAULT_CH = 6'(DEFAULT_CHANNEL);
    localparam logic [BIT_COUNT_WIDTH-1:0] HDR_LEN    = BIT_COUNT_WIDTH'(HEADER_BIT_LEN);
    localparam logic                       HDR_ONE    = (HEADER_BIT_LEN == 1);

    // Seed places the channel index bit-reversed in s[6:1] with s[0] forced high.
    function automatic logic [6:0] lfsr_seed(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    endfunction

    state_t                     state;
    logic [5:0]                 channel_reg;
    logic [6:0]                 lfsr;
    logic [BIT_COUNT_WIDTH-1:0] bit_count;

    logic [6:0]                 lfsr_step;
    logic [BIT_COUNT_WIDTH-1:0] bit_count_inc;
    logic [5:0]                 idle_channel;

    // One whitening step; s[6] is the output tap fed back into s[0] and s[4].
    assign lfsr_step     = {lfsr[5:4], lfsr[3] ^ lfsr[6], lfsr[2:0], lfsr[6]};
    assign bit_count_inc = bit_count + 1'b1;
    // In IDLE a same-cycle load takes effect before the bit is processed.
    assign idle_channel  = channel_number_load ? channel_number : channel_reg;

    // Packet FSM, whitening LFSR and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                               <= IDLE;
            channel_reg                         <= DEFAULT_CH;
            lfsr                                <= lfsr_seed(DEFAULT_CH);
            bit_count                           <= '0;
            info_bit_after_whitening            <= 1'b0;
            info_bit_after_whitening_valid      <= 1'b0;
            info_bit_after_whitening_valid_last <= 1'b0;
        end else begin
            info_bit_after_whitening_valid      <= info_bit_valid;
            info_bit_after_whitening_valid_last <= info_bit_valid & info_bit_valid_last;

            case (state)
                IDLE: begin
                    if (channel_number_load) begin
                        channel_reg <= channel_number;
                        lfsr        <= lfsr_seed(channel_number);
                    end
                    if (info_bit_valid) begin
                        info_bit_after_whitening <= info_bit;
                        if (info_bit_valid_last) begin
                            bit_count <= '0;
                            lfsr      <= lfsr_seed(idle_channel);
                        end else begin
                            bit_count <= BIT_COUNT_WIDTH'(1);
                            state     <= HDR_ONE ? WHITEN : HEADER;
                        end
                    end
                end

                HEADER: begin
                    if (info_bit_valid) begin
                        info_bit_after_whitening <= info_bit;
                        if (info_bit_valid_last) begin
                            state     <= IDLE;
                            bit_count <= '0;
                            lfsr      <= lfsr_seed(channel_reg);
                        end else if (bit_count_inc >= HDR_LEN) begin
                            // Counter saturates here; it never advances in WHITEN.
                            state     <= WHITEN;
                            bit_count <= HDR_LEN;
                        end else begin
                            bit_count <= bit_count_inc;
                        end
                    end
                end

                WHITEN: begin
                    if (info_bit_valid) begin
                        info_bit_after_whitening <= info_bit ^ lfsr[6];
                        if (info_bit_valid_last) begin
                            state     <= IDLE;
                            bit_count <= '0;
                            lfsr      <= lfsr_seed(channel_reg);
                        end else begin
                            lfsr <= lfsr_step;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    bit_count <= '0;
                    lfsr      <= lfsr_seed(channel_reg);
                end
            endcase
        end
    end

endmodule
